spectrum_param_extract: RTL and testbench
=========================================

// Module: spectrum_param_extract
// PURPOSE
//  Measures modulation parameters from the 256x16 FFT-magnitude RAM after a frame has been written.
//  Shares the RAM read port (rd_addr/rd_data) with modulation_detect, which it follows.
//  Finds the carrier peak bin and the strongest upper sideband, then derives modulation frequency
//  (0.1 kHz units) and AM index ma (percent) or FM sideband count. Drives mod_freq/mod_param1 to seg_led.
// PARAMETERS
//  BIN_HZ       16'd391  spectrum bin spacing in Hz (Fs/256)
//  FIRST_BIN    8'd1     lowest bin scanned for the carrier (skips DC)
//  LAST_BIN     8'd127   highest bin scanned (positive half of spectrum)
//  SB_WIN       8'd16    bins above carrier searched for sidebands
//  THR_SHIFT    3'd3     FM sideband counted if mag > carrier >> THR_SHIFT
// PORTS
//  clk          in   1   50 MHz system clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   rising edge starts a measurement (connect wr_done)
//  mod_type     in   3   001 CW, 010 AM, 100 FM; sampled at start
//  rd_addr      out  8   RAM read address
//  rd_data      in   16  RAM magnitude; valid exactly 1 clk after rd_addr
//  busy         out  1   high from start accepted until done
//  param_valid  out  1   1-clk pulse when outputs update
//  mod_freq     out  8   modulation frequency, units of 100 Hz, saturates at 255
//  mod_param1   out  8   AM: ma in %, clamp 100; FM: sideband count; CW: 0
//  err          out  1   set when carrier magnitude is 0; cleared at next start
// BEHAVIOUR
//  Reset: rd_addr=0, busy=0, param_valid=0, mod_freq=0, mod_param1=0, err=0, FSM=IDLE.
//  Start detection: registered edge detect on start; edges while busy=1 are ignored.
//  FSM: IDLE -> PEAK -> SB -> DIV -> DONE -> IDLE.
//   IDLE: on edge latch mod_type, busy<=1, rd_addr<=FIRST_BIN, go PEAK.
//   PEAK: issue FIRST_BIN..LAST_BIN one per clk; compare rd_data with 1-clk delayed address tag.
//         Strict '>' so lowest bin wins on ties -> kc, Ac. Leaves after last data returns.
//         If Ac==0: err<=1, outputs=0, go DONE. If mod_type==CW: outputs=0, go DONE.
//   SB: scan kc+1..min(kc+SB_WIN, LAST_BIN); track max As/ks (strict '>'),
//       and count bins with rd_data > (Ac>>THR_SHIFT) (8-bit saturating). If kc==LAST_BIN window empty: As=0, ks=kc.
//   DIV: one 24/16 restoring divider, 1 quotient bit/clk, used twice serially:
//        pass1 freq = ((ks-kc)*BIN_HZ)/100; pass2 AM only: ma = (200*As)/Ac.
//        Results saturate to 255 (freq) and clamp to 100 (ma); FM mod_param1 = sideband count.
//   DONE: mod_freq/mod_param1 update together, param_valid=1 for one clk, busy<=0, go IDLE.
//  Outputs hold last result between runs; they never change except in DONE or reset.
//  Latency (AM, defaults): ~127+1 PEAK + <=17 SB + 2x24 DIV + 2 overhead < 200 clks.
//  Reset asserted mid-run: immediate return to reset state; no param_valid; partial results discarded.
//  mod_type changes mid-run are ignored (latched copy used).
// TESTING
//  1 AM: RAM bin10=1000, bin13=250, rest 0, mod_type=010, start pulse -> mod_freq=11 (3*391/100),
//    mod_param1=50, err=0, one param_valid pulse, busy low after.
//  2 CW: bin20=800 only, mod_type=001 -> mod_freq=0, mod_param1=0, param_valid pulse, busy ~130 clks.
//  3 FM: bin30=400, bins31..35=100, THR_SHIFT=3 -> mod_param1=5, mod_freq=3 (1*391/100).
//  4 All-zero RAM, AM -> err=1, mod_freq=0, mod_param1=0; next valid frame clears err.
//  5 Tie/edge: bins 40 and 60 both 500, bin127 carrier case: kc=40 chosen; carrier at 127 -> mod_freq=0.
//  6 Second start during busy ignored (one param_valid); rst_n low mid-PEAK -> all outputs 0, no pulse.

Source files
------------

// File: rtl/spectrum_param_extract_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spectrum_param_extract_if
//  Brief    : Start/result handshake and shared spectrum-RAM read port
//  Revision : 1.0  initial release
// ============================================================================
interface spectrum_param_extract_if;
  logic        start;
  logic [2:0]  mod_type;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        param_valid;
  logic [7:0]  mod_freq;
  logic [7:0]  mod_param1;
  logic        err;

  // slave: the extractor itself; master: the frame writer / RAM / display side
  modport slave (
    input  start, mod_type, rd_data,
    output rd_addr, busy, param_valid, mod_freq, mod_param1, err
  );
  modport master (
    output start, mod_type, rd_data,
    input  rd_addr, busy, param_valid, mod_freq, mod_param1, err
  );
endinterface
`default_nettype wire

// File: rtl/spectrum_param_extract.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spectrum_param_extract
//  Brief    : Carrier/sideband search over FFT magnitudes; derives mod freq and ma / FM count
//  Revision : 1.0  initial release
// ============================================================================
module spectrum_param_extract #(
  parameter logic [15:0] BIN_HZ    = 16'd391,
  parameter logic [7:0]  FIRST_BIN = 8'd1,
  parameter logic [7:0]  LAST_BIN  = 8'd127,
  parameter logic [7:0]  SB_WIN    = 8'd16,
  parameter logic [2:0]  THR_SHIFT = 3'd3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  spectrum_param_extract_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEAK = 3'd1,
    S_SB   = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0]  C_MT_CW    = 3'b001;
  localparam logic [2:0]  C_MT_AM    = 3'b010;
  localparam logic [2:0]  C_MT_FM    = 3'b100;
  localparam logic [15:0] C_FREQ_DIV = 16'd100;
  localparam logic [4:0]  C_DIV_BITS = 5'd24;

  state_t      r_state;
  logic        r_start_d;
  logic [2:0]  r_mt;
  logic [7:0]  r_rd_addr;
  logic        r_iss;
  logic [7:0]  r_lim;
  logic [7:0]  r_tag;
  logic        r_tag_vld;
  logic [7:0]  r_kc;
  logic [15:0] r_ac;
  logic [7:0]  r_ks;
  logic [15:0] r_as;
  logic [7:0]  r_cnt;
  logic        r_pass;
  logic        r_div_ld;
  logic [4:0]  r_dcnt;
  logic [15:0] r_rem;
  logic [23:0] r_quo;
  logic [15:0] r_div_d;
  logic [7:0]  r_res_freq;
  logic [7:0]  r_res_p1;
  logic        r_busy;
  logic        r_pv;
  logic [7:0]  r_freq;
  logic [7:0]  r_p1;
  logic        r_err;

  logic        w_edge;
  logic        w_last;
  logic        w_pk_upd;
  logic [15:0] w_ac_nxt;
  logic [7:0]  w_kc_nxt;
  logic        w_sb_upd;
  logic [15:0] w_as_nxt;
  logic [7:0]  w_ks_nxt;
  logic [15:0] w_thr;
  logic [7:0]  w_cnt_nxt;
  logic [8:0]  w_win_end9;
  logic [7:0]  w_win_end;
  logic [7:0]  w_dlt;
  logic [23:0] w_dfreq;
  logic [23:0] w_dma;
  logic [16:0] w_shift;
  logic        w_ge;
  logic [15:0] w_sub;

  assign w_edge   = bus.start & ~r_start_d;
  // The data returning now belongs to the address issued one clock earlier (r_tag).
  assign w_last   = r_tag_vld && (r_tag == r_lim);

  assign w_pk_upd = r_tag_vld && (bus.rd_data > r_ac);
  assign w_ac_nxt = w_pk_upd ? bus.rd_data : r_ac;
  assign w_kc_nxt = w_pk_upd ? r_tag : r_kc;

  assign w_sb_upd = r_tag_vld && (bus.rd_data > r_as);
  assign w_as_nxt = w_sb_upd ? bus.rd_data : r_as;
  assign w_ks_nxt = w_sb_upd ? r_tag : r_ks;

  assign w_thr     = r_ac >> THR_SHIFT;
  assign w_cnt_nxt = (r_tag_vld && (bus.rd_data > w_thr) && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;

  assign w_win_end9 = {1'b0, w_kc_nxt} + {1'b0, SB_WIN};
  assign w_win_end  = (w_win_end9 > {1'b0, LAST_BIN}) ? LAST_BIN : w_win_end9[7:0];

  assign w_dlt   = r_ks - r_kc;
  assign w_dfreq = {16'd0, w_dlt} * {8'd0, BIN_HZ};
  assign w_dma   = {8'd0, r_as} * 24'd200;

  // Restoring division step: bring down next dividend bit, subtract if it fits.
  assign w_shift = {r_rem, r_quo[23]};
  assign w_ge    = (w_shift >= {1'b0, r_div_d});
  assign w_sub   = w_shift[15:0] - r_div_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_mt       <= 3'd0;
      r_rd_addr  <= 8'd0;
      r_iss      <= 1'b0;
      r_lim      <= 8'd0;
      r_tag      <= 8'd0;
      r_tag_vld  <= 1'b0;
      r_kc       <= 8'd0;
      r_ac       <= 16'd0;
      r_ks       <= 8'd0;
      r_as       <= 16'd0;
      r_cnt      <= 8'd0;
      r_pass     <= 1'b0;
      r_div_ld   <= 1'b0;
      r_dcnt     <= 5'd0;
      r_rem      <= 16'd0;
      r_quo      <= 24'd0;
      r_div_d    <= 16'd0;
      r_res_freq <= 8'd0;
      r_res_p1   <= 8'd0;
      r_busy     <= 1'b0;
      r_pv       <= 1'b0;
      r_freq     <= 8'd0;
      r_p1       <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_start_d <= bus.start;
      r_pv      <= 1'b0;
      r_tag_vld <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_mt      <= bus.mod_type;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_rd_addr <= FIRST_BIN;
            r_iss     <= 1'b1;
            r_lim     <= LAST_BIN;
            r_ac      <= 16'd0;
            r_kc      <= FIRST_BIN;
            r_state   <= S_PEAK;
          end
        end

        S_PEAK, S_SB: begin
          r_tag     <= r_rd_addr;
          r_tag_vld <= r_iss;
          if (r_iss) begin
            if (r_rd_addr == r_lim) r_iss     <= 1'b0;
            else                    r_rd_addr <= r_rd_addr + 8'd1;
          end

          if (r_state == S_PEAK) begin
            r_ac <= w_ac_nxt;
            r_kc <= w_kc_nxt;
            if (w_last) begin
              r_as  <= 16'd0;
              r_ks  <= w_kc_nxt;
              r_cnt <= 8'd0;
              if (w_ac_nxt == 16'd0) begin
                r_err      <= 1'b1;
                r_res_freq <= 8'd0;
                r_res_p1   <= 8'd0;
                r_state    <= S_DONE;
              end else if (r_mt == C_MT_CW) begin
                r_res_freq <= 8'd0;
                r_res_p1   <= 8'd0;
                r_state    <= S_DONE;
              end else if (w_kc_nxt == LAST_BIN) begin
                r_pass   <= 1'b0;
                r_div_ld <= 1'b1;
                r_state  <= S_DIV;
              end else begin
                r_rd_addr <= w_kc_nxt + 8'd1;
                r_iss     <= 1'b1;
                r_lim     <= w_win_end;
                r_state   <= S_SB;
              end
            end
          end else begin
            r_as  <= w_as_nxt;
            r_ks  <= w_ks_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_pass   <= 1'b0;
              r_div_ld <= 1'b1;
              r_state  <= S_DIV;
            end
          end
        end

        S_DIV: begin
          if (r_div_ld) begin
            r_div_ld <= 1'b0;
            r_dcnt   <= 5'd0;
            r_rem    <= 16'd0;
            r_quo    <= r_pass ? w_dma : w_dfreq;
            r_div_d  <= r_pass ? r_ac : C_FREQ_DIV;
          end else if (r_dcnt != C_DIV_BITS) begin
            r_rem  <= w_ge ? w_sub : w_shift[15:0];
            r_quo  <= {r_quo[22:0], w_ge};
            r_dcnt <= r_dcnt + 5'd1;
          end else if (!r_pass) begin
            r_res_freq <= (|r_quo[23:8]) ? 8'hFF : r_quo[7:0];
            if (r_mt == C_MT_AM) begin
              r_pass   <= 1'b1;
              r_div_ld <= 1'b1;
            end else begin
              r_res_p1 <= (r_mt == C_MT_FM) ? r_cnt : 8'd0;
              r_state  <= S_DONE;
            end
          end else begin
            r_res_p1 <= (r_quo > 24'd100) ? 8'd100 : r_quo[7:0];
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          r_freq  <= r_res_freq;
          r_p1    <= r_res_p1;
          r_pv    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_addr     = r_rd_addr;
  assign bus.busy        = r_busy;
  assign bus.param_valid = r_pv;
  assign bus.mod_freq    = r_freq;
  assign bus.mod_param1  = r_p1;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_param_extract.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spectrum_param_extract
//  Brief    : Directed scoreboard bench for spectrum_param_extract with a 1-clk RAM model
//  Revision : 1.0  initial release
// ============================================================================
module tb_spectrum_param_extract;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] p;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  spectrum_param_extract_if bus ();

  spectrum_param_extract dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [0:255];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int   n_vec = 0;
  int   n_mis = 0;
  int   n_pv  = 0;
  exp_t sb_q[$];

  always @(posedge clk) if (bus.param_valid === 1'b1) n_pv++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
  endtask

  // Pulse start, scramble mod_type afterwards, wait for param_valid and score it.
  task automatic run_frame(input logic [2:0] mt, input logic [7:0] ef, input logic [7:0] ep,
                           input logic ee, input int dbl_at, input string tag, output int lat);
    exp_t x;
    int   cyc;
    int   pv0;
    x = '{f: ef, p: ep, e: ee};
    sb_q.push_back(x);
    pv0 = n_pv;
    @(negedge clk);
    bus.mod_type = mt;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.mod_type = 3'b011;
    cyc = 1;
    while (bus.param_valid !== 1'b1 && cyc < 400) begin
      if (cyc == dbl_at)     bus.start = 1'b1;
      if (cyc == dbl_at + 1) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    x = sb_q.pop_front();
    if (bus.param_valid !== 1'b1) begin
      chk({tag, "_timeout"}, {31'd0, bus.param_valid}, 32'd1);
    end else begin
      chk({tag, "_freq"}, {24'd0, bus.mod_freq}, {24'd0, x.f});
      chk({tag, "_p1"},   {24'd0, bus.mod_param1}, {24'd0, x.p});
      chk({tag, "_err"},  {31'd0, bus.err}, {31'd0, x.e});
      chk({tag, "_busy_at_pv"}, {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_pv_1clk"}, {31'd0, bus.param_valid}, 32'd0);
      chk({tag, "_pv_count"}, n_pv - pv0, 32'd1);
    end
  endtask

  int lat;
  int pv_snap;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.mod_type = 3'b000;
    clr_mem();
    repeat (3) @(negedge clk);
    chk("rst_rd_addr", {24'd0, bus.rd_addr}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("rst_pv",      {31'd0, bus.param_valid}, 32'd0);
    chk("rst_freq",    {24'd0, bus.mod_freq}, 32'd0);
    chk("rst_p1",      {24'd0, bus.mod_param1}, 32'd0);
    chk("rst_err",     {31'd0, bus.err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AM: carrier bin10, sideband bin13 -> 3*391/100=11, 200*250/1000=50
    clr_mem(); mem[10] = 16'd1000; mem[13] = 16'd250;
    run_frame(3'b010, 8'd11, 8'd50, 1'b0, -10, "am", lat);
    chk("am_latency_lt200", {31'd0, lat < 200}, 32'd1);
    chk("am_busy_after", {31'd0, bus.busy}, 32'd0);

    // CW: outputs zero, busy spans the full peak scan (~130 clocks)
    clr_mem(); mem[20] = 16'd800;
    run_frame(3'b001, 8'd0, 8'd0, 1'b0, -10, "cw", lat);
    chk("cw_busy_len", {31'd0, (lat >= 125) && (lat <= 135)}, 32'd1);

    // FM: 5 sidebands above 400>>3=50; bin36 equals threshold and is not counted
    clr_mem(); mem[30] = 16'd400;
    for (int b = 31; b <= 35; b++) mem[b] = 16'd100;
    mem[36] = 16'd50;
    run_frame(3'b100, 8'd3, 8'd5, 1'b0, -10, "fm", lat);

    // All-zero frame flags err; err holds until the next accepted start
    clr_mem();
    run_frame(3'b010, 8'd0, 8'd0, 1'b1, -10, "zero", lat);
    repeat (5) @(negedge clk);
    chk("zero_err_holds", {31'd0, bus.err}, 32'd1);
    clr_mem(); mem[10] = 16'd1000; mem[13] = 16'd250;
    run_frame(3'b010, 8'd11, 8'd50, 1'b0, -10, "err_clear", lat);

    // Tie: bins 40 and 60 equal -> lowest (40) is carrier, sideband at 43
    clr_mem(); mem[40] = 16'd500; mem[60] = 16'd500; mem[43] = 16'd100;
    run_frame(3'b010, 8'd11, 8'd40, 1'b0, -10, "tie", lat);

    // Carrier at the top bin: empty sideband window
    clr_mem(); mem[127] = 16'd900;
    run_frame(3'b010, 8'd0, 8'd0, 1'b0, -10, "top_bin", lat);

    // Sideband equal to carrier -> ma=200 clamped to 100; freq 2*391/100=7
    clr_mem(); mem[10] = 16'd1000; mem[12] = 16'd1000;
    run_frame(3'b010, 8'd7, 8'd100, 1'b0, -10, "ma_clamp", lat);

    // Second start edge while busy is ignored
    clr_mem(); mem[30] = 16'd400; mem[32] = 16'd300;
    pv_snap = n_pv;
    run_frame(3'b100, 8'd7, 8'd1, 1'b0, 20, "dbl_start", lat);
    repeat (300) @(negedge clk);
    chk("dbl_start_one_pv", n_pv - pv_snap, 32'd1);

    // Reset mid-PEAK: outputs clear immediately and no pulse follows
    clr_mem(); mem[10] = 16'd1000; mem[13] = 16'd250;
    pv_snap = n_pv;
    @(negedge clk);
    bus.mod_type = 3'b010;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    repeat (50) @(negedge clk);
    chk("midrun_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_addr", {24'd0, bus.rd_addr}, 32'd0);
    chk("midrst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("midrst_freq",    {24'd0, bus.mod_freq}, 32'd0);
    chk("midrst_p1",      {24'd0, bus.mod_param1}, 32'd0);
    chk("midrst_err",     {31'd0, bus.err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_pv", n_pv - pv_snap, 32'd0);
    chk("midrst_freq_hold", {24'd0, bus.mod_freq}, 32'd0);

    // Recovery after reset
    run_frame(3'b010, 8'd11, 8'd50, 1'b0, -10, "recover", lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
